// File: rtl/pps_phase_meas_multi.sv
`default_nettype none
// ============================================================================
// Module      : pps_phase_meas_multi
// Description : N-channel PPS phase comparator in the measurement clock
//               domain. Every channel edge is timestamped against a
//               free-running counter; a reference-channel edge opens a
//               window of WIN_CYC clocks, after which signed per-channel
//               offsets (channel minus reference) and hit flags are
//               published.
// Ports       : i_clk       measurement clock
//               i_res_n     asynchronous active-low reset
//               i_en        measurement enable (0 aborts and idles)
//               i_clr       clears o_ref_ovr
//               i_edge_pol  per-channel edge select, 0 rising / 1 falling
//               i_pps       asynchronous PPS inputs
//               o_valid     one-cycle pulse, result outputs updated
//               o_ts_ref    reference edge timestamp
//               o_diff      signed offsets, ch k in [k*CW +: CW]
//               o_hit       ch k had a fresh edge with |diff| <= WIN_CYC
//               o_seq       result sequence number
//               o_ref_ovr   sticky: reference edge while not idle
// Revision    : 1.0 - initial release
// ============================================================================
module pps_phase_meas_multi #(
    parameter int NCH      = 4,
    parameter int CW       = 29,
    parameter int SYNC_STG = 2,
    parameter int REF_CH   = 0,
    parameter int WIN_CYC  = 400000
) (
    input  logic              i_clk,
    input  logic              i_res_n,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [NCH-1:0]    i_edge_pol,
    input  logic [NCH-1:0]    i_pps,
    output logic              o_valid,
    output logic [CW-1:0]     o_ts_ref,
    output logic [NCH*CW-1:0] o_diff,
    output logic [NCH-1:0]    o_hit,
    output logic [7:0]        o_seq,
    output logic              o_ref_ovr
);

    localparam int                 c_WIN_W    = $clog2(WIN_CYC + 1);
    localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(WIN_CYC - 1);
    localparam logic signed [CW-1:0] c_WIN_POS = CW'(WIN_CYC);
    localparam logic signed [CW-1:0] c_WIN_NEG = CW'(-WIN_CYC);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WINDOW = 2'd1,
        S_CALC   = 2'd2,
        S_PUB    = 2'd3
    } state_t;

    logic [CW-1:0]      r_cnt;
    logic [NCH-1:0]     r_sync [SYNC_STG];
    logic [NCH-1:0]     r_prev;
    logic [NCH-1:0]     r_fresh;
    logic [CW-1:0]      r_ts [NCH];
    state_t             r_state;
    logic [c_WIN_W-1:0] r_win;

    logic               r_valid;
    logic [CW-1:0]      r_ts_ref;
    logic [NCH*CW-1:0]  r_diff;
    logic [NCH-1:0]     r_hit;
    logic [7:0]         r_seq;
    logic               r_ovr;

    logic [NCH-1:0]     w_sync_out;
    logic [NCH-1:0]     w_edge;
    logic [NCH*CW-1:0]  w_diff;
    logic [NCH-1:0]     w_hit;

    assign w_sync_out = r_sync[SYNC_STG-1];
    // The previous sample is kept raw and polarity is applied to both sides,
    // so a polarity change alone never looks like an edge.
    assign w_edge = (w_sync_out ^ i_edge_pol) & ~(r_prev ^ i_edge_pol);

    // Free-running counter and input synchronisers
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            for (int s = 0; s < SYNC_STG; s++) begin
                r_sync[s] <= '0;
            end
            r_prev <= '0;
            r_cnt  <= '0;
        end else begin
            r_sync[0] <= i_pps;
            for (int s = 1; s < SYNC_STG; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev <= w_sync_out;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // Timestamp capture (last edge wins) and fresh flags
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            for (int k = 0; k < NCH; k++) begin
                r_ts[k] <= '0;
            end
            r_fresh <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (w_edge[k]) begin
                    r_ts[k] <= r_cnt;
                end
            end
            if (!i_en) begin
                r_fresh <= '0;
            end else if (r_state == S_PUB) begin
                // An edge landing on the publish cycle belongs to the next result
                r_fresh <= w_edge;
            end else begin
                r_fresh <= r_fresh | w_edge;
            end
        end
    end

    // Offsets are taken modulo 2^CW so a counter wrap inside the window is harmless
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic signed [CW-1:0] w_d;
        if (k == REF_CH) begin : g_ref
            assign w_d      = '0;
            assign w_hit[k] = 1'b1;
        end else begin : g_oth
            assign w_d      = $signed(r_ts[k] - r_ts[REF_CH]);
            assign w_hit[k] = r_fresh[k] && (w_d <= c_WIN_POS) && (w_d >= c_WIN_NEG);
        end
        assign w_diff[k*CW +: CW] = w_d;
    end

    // Window FSM with registered result outputs. Results are registered on
    // leaving CALC so they appear together with o_valid in the PUB cycle.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            r_state  <= S_IDLE;
            r_win    <= '0;
            r_valid  <= 1'b0;
            r_ts_ref <= '0;
            r_diff   <= '0;
            r_hit    <= '0;
            r_seq    <= '0;
        end else begin
            r_valid <= 1'b0;
            if (!i_en) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_edge[REF_CH]) begin
                            r_state <= S_WINDOW;
                            r_win   <= '0;
                        end
                    end
                    S_WINDOW: begin
                        if (r_win == c_WIN_LAST) begin
                            r_state <= S_CALC;
                        end else begin
                            r_win <= r_win + 1'b1;
                        end
                    end
                    S_CALC: begin
                        r_state  <= S_PUB;
                        r_valid  <= 1'b1;
                        r_ts_ref <= r_ts[REF_CH];
                        r_diff   <= w_diff;
                        r_hit    <= w_hit;
                        r_seq    <= r_seq + 8'd1;
                    end
                    S_PUB: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Overrun flag: a new reference edge while busy; setting beats clearing
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            r_ovr <= 1'b0;
        end else if (w_edge[REF_CH] && (r_state != S_IDLE)) begin
            r_ovr <= 1'b1;
        end else if (i_clr) begin
            r_ovr <= 1'b0;
        end
    end

    assign o_valid   = r_valid;
    assign o_ts_ref  = r_ts_ref;
    assign o_diff    = r_diff;
    assign o_hit     = r_hit;
    assign o_seq     = r_seq;
    assign o_ref_ovr = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_pps_phase_meas_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_pps_phase_meas_multi
// Description : Self-checking bench for pps_phase_meas_multi. Fixed vectors
//               with constant expectations plus randomized windows checked
//               against an event-level model (timestamps, fresh flags,
//               sequence and overrun state).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pps_phase_meas_multi;

    localparam int NCH  = 4;
    localparam int CW   = 12;
    localparam int SYNC = 2;
    localparam int REF  = 0;
    localparam int W    = 128;
    localparam int MOD  = 1 << CW;
    localparam int LEAD = W + 8;

    logic              i_clk = 1'b0;
    logic              i_res_n;
    logic              i_en;
    logic              i_clr;
    logic [NCH-1:0]    i_edge_pol;
    logic [NCH-1:0]    i_pps;
    logic              o_valid;
    logic [CW-1:0]     o_ts_ref;
    logic [NCH*CW-1:0] o_diff;
    logic [NCH-1:0]    o_hit;
    logic [7:0]        o_seq;
    logic              o_ref_ovr;

    pps_phase_meas_multi #(
        .NCH(NCH), .CW(CW), .SYNC_STG(SYNC), .REF_CH(REF), .WIN_CYC(W)
    ) dut (
        .i_clk(i_clk), .i_res_n(i_res_n), .i_en(i_en), .i_clr(i_clr),
        .i_edge_pol(i_edge_pol), .i_pps(i_pps), .o_valid(o_valid),
        .o_ts_ref(o_ts_ref), .o_diff(o_diff), .o_hit(o_hit), .o_seq(o_seq),
        .o_ref_ovr(o_ref_ovr)
    );

    always #5 i_clk = ~i_clk;

    // Clocks elapsed since reset release; equals the DUT counter mod 2^CW
    int cyc;
    always @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    int nval = 0;
    int vcyc = 0;
    always @(negedge i_clk) begin
        if (o_valid === 1'b1) begin
            nval <= nval + 1;
            vcyc <= cyc;
        end
    end

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int             ts_m [NCH];
    logic [NCH-1:0] fresh_m;
    int             seq_m;
    logic           ovr_m;

    typedef struct packed {
        logic [NCH-1:0][15:0] offs;
        logic [NCH-1:0]       pres;
        logic [NCH-1:0]       pol;
        int                   tgt;
        logic [NCH-1:0][15:0] ediff;
        logic [NCH-1:0]       dchk;
        logic [NCH-1:0]       ehit;
    } vec_t;

    vec_t tbl [5];

    function automatic vec_t mk(input int o0, input int o1, input int o2, input int o3,
                                input logic [NCH-1:0] pres, input logic [NCH-1:0] pol,
                                input int tgt, input int e0, input int e1, input int e2,
                                input int e3, input logic [NCH-1:0] dchk,
                                input logic [NCH-1:0] ehit);
        vec_t v;
        v.offs  = {16'(o3), 16'(o2), 16'(o1), 16'(o0)};
        v.pres  = pres;
        v.pol   = pol;
        v.tgt   = tgt;
        v.ediff = {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
        v.dchk  = dchk;
        v.ehit  = ehit;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_tsref"}, 64'(o_ts_ref), 64'd0);
        chk({tag, "_diff"}, 64'(o_diff), 64'd0);
        chk({tag, "_hit"}, 64'(o_hit), 64'd0);
        chk({tag, "_seq"}, 64'(o_seq), 64'd0);
        chk({tag, "_ovr"}, 64'(o_ref_ovr), 64'd0);
    endtask

    function automatic int sdiff(input int a, input int b);
        int d;
        d = ((a - b) % MOD + MOD) % MOD;
        if (d >= MOD / 2) d -= MOD;
        return d;
    endfunction

    // One measurement window. Called and returns on a falling clock edge.
    // Offsets are in clocks relative to the reference drive cycle.
    task automatic run_scn(input logic [NCH-1:0][15:0] offs, input logic [NCH-1:0] pres,
                           input int tgt, input int ovr_off, input int drop_at,
                           input bit chk_vals);
        int c0, cr, end_c, lead, nv0, o;
        int dm [NCH];
        logic [NCH-1:0] hm;
        int tsr;
        bit exp_v;
        c0   = cyc;
        lead = LEAD;
        if (tgt >= 0) begin
            lead = ((tgt - (c0 % MOD)) % MOD + MOD) % MOD;
            if (lead < LEAD) lead += MOD;
        end
        cr    = c0 + lead;
        end_c = cr + 2 * W + 12;
        nv0   = nval;
        exp_v = (drop_at == 0);
        hm    = '0;
        tsr   = 0;
        for (int k = 0; k < NCH; k++) dm[k] = 0;
        for (int c = c0; c <= end_c; c++) begin
            for (int k = 0; k < NCH; k++) begin
                if (pres[k]) begin
                    o = int'($signed(offs[k]));
                    if (c == cr + o) begin
                        i_pps[k]   = ~i_edge_pol[k];
                        ts_m[k]    = (c + SYNC) % MOD;
                        fresh_m[k] = 1'b1;
                    end
                    if (c == cr + o + 4) i_pps[k] = i_edge_pol[k];
                end
            end
            if (ovr_off != 0) begin
                if (c == cr + ovr_off) begin
                    i_pps[REF] = ~i_edge_pol[REF];
                    ts_m[REF]  = (c + SYNC) % MOD;
                    ovr_m      = 1'b1;
                end
                if (c == cr + ovr_off + 4) i_pps[REF] = i_edge_pol[REF];
            end
            if (drop_at != 0 && c == cr + drop_at) begin
                i_en    = 1'b0;
                fresh_m = '0;
            end
            if (drop_at != 0 && c == cr + drop_at + 3) i_en = 1'b1;
            if (exp_v && c == cr + W) begin
                tsr = ts_m[REF];
                for (int k = 0; k < NCH; k++) begin
                    if (k == REF) begin
                        dm[k] = 0;
                        hm[k] = 1'b1;
                    end else begin
                        dm[k] = sdiff(ts_m[k], ts_m[REF]);
                        hm[k] = fresh_m[k] && (dm[k] <= W) && (dm[k] >= -W);
                    end
                end
                seq_m   = (seq_m + 1) % 256;
                fresh_m = '0;
            end
            @(negedge i_clk);
        end
        if (exp_v) begin
            chk("nvalid", 64'(nval - nv0), 64'd1);
            chk("latency", 64'(vcyc), 64'(cr + W + SYNC + 2));
            chk("seq", 64'(o_seq), 64'(seq_m));
            if (chk_vals) begin
                chk("ts_ref", 64'(o_ts_ref), 64'(tsr));
                for (int k = 0; k < NCH; k++)
                    chk($sformatf("diff%0d", k), 64'(o_diff[k*CW +: CW]), 64'(dm[k][CW-1:0]));
                chk("hit", 64'(o_hit), 64'(hm));
            end
        end else begin
            chk("no_valid", 64'(nval - nv0), 64'd0);
            chk("seq_hold", 64'(o_seq), 64'(seq_m));
        end
        chk("ref_ovr", 64'(o_ref_ovr), 64'(ovr_m));
    endtask

    initial begin
        logic [NCH-1:0][15:0] roffs;
        logic [NCH-1:0]       rpres;
        int nv0;

        tbl[0] = mk(0, 40, -25, 0, 4'hF, 4'h0, -1, 0, 40, -25, 0, 4'hF, 4'hF);
        tbl[1] = mk(0, 10, 2*W, 0, 4'b0111, 4'h0, -1, 0, 10, 0, 0, 4'b0011, 4'b0011);
        tbl[2] = mk(0, 20, 5, -3, 4'hF, 4'h0, MOD - 12, 0, 20, 5, -3, 4'hF, 4'hF);
        tbl[3] = mk(0, 100, -7, 33, 4'hF, 4'b0010, -1, 0, 100, -7, 33, 4'hF, 4'hF);
        tbl[4] = mk(0, W, -W, -W-1, 4'hF, 4'b0010, -1, 0, W, -W, -W-1, 4'hF, 4'b0111);

        i_res_n    = 1'b0;
        i_en       = 1'b0;
        i_clr      = 1'b0;
        i_edge_pol = '0;
        i_pps      = '0;
        for (int k = 0; k < NCH; k++) ts_m[k] = 0;
        fresh_m = '0;
        seq_m   = 0;
        ovr_m   = 1'b0;

        repeat (3) @(negedge i_clk);
        chk_zero("reset");
        i_res_n = 1'b1;
        i_en    = 1'b1;
        repeat (4) @(negedge i_clk);

        // Fixed vectors with constant expectations
        for (int i = 0; i < 5; i++) begin
            if (tbl[i].pol != i_edge_pol) begin
                i_en       = 1'b0;
                fresh_m    = '0;
                i_edge_pol = tbl[i].pol;
                i_pps      = tbl[i].pol;
                repeat (6) @(negedge i_clk);
                i_en = 1'b1;
            end
            run_scn(tbl[i].offs, tbl[i].pres, tbl[i].tgt, 0, 0, 1'b1);
            for (int k = 0; k < NCH; k++)
                if (tbl[i].dchk[k])
                    chk($sformatf("v%0d_diff%0d", i, k), 64'(o_diff[k*CW +: CW]),
                        64'(tbl[i].ediff[k][CW-1:0]));
            chk($sformatf("v%0d_hit", i), 64'(o_hit), 64'(tbl[i].ehit));
        end

        // Second reference edge inside the window, then clear
        run_scn(tbl[0].offs, 4'b0001, -1, 30, 0, 1'b0);
        chk("ovr_set", 64'(o_ref_ovr), 64'd1);
        i_clr = 1'b1;
        @(negedge i_clk);
        i_clr = 1'b0;
        ovr_m = 1'b0;
        chk("ovr_clr", 64'(o_ref_ovr), 64'd0);

        // Enable dropped mid-window, then a normal window continues the sequence
        run_scn(tbl[0].offs, 4'hF, -1, 0, W / 2, 1'b0);
        run_scn(tbl[3].offs, 4'hF, -1, 0, 0, 1'b1);

        // Randomized windows against the model
        for (int r = 0; r < 8; r++) begin
            rpres = 4'($urandom_range(0, 15)) | 4'b0001;
            roffs = '0;
            for (int k = 1; k < NCH; k++) begin
                if ($urandom_range(0, 3) == 0)
                    roffs[k] = 16'(W + 10 + int'($urandom_range(0, W - 10)));
                else
                    roffs[k] = 16'(int'($urandom_range(0, 2 * W + 5)) - (W + 5));
            end
            run_scn(roffs, rpres, -1, 0, 0, 1'b1);
        end

        // Asynchronous reset in the middle of a window
        nv0 = nval;
        i_pps[REF] = ~i_edge_pol[REF];
        repeat (4) @(negedge i_clk);
        i_pps[REF] = i_edge_pol[REF];
        repeat (W / 2) @(negedge i_clk);
        #2 i_res_n = 1'b0;
        #1 chk_zero("midreset");
        @(negedge i_clk);
        i_res_n = 1'b1;
        for (int k = 0; k < NCH; k++) ts_m[k] = 0;
        fresh_m = '0;
        seq_m   = 0;
        ovr_m   = 1'b0;
        repeat (W + 8) @(negedge i_clk);
        chk("reset_no_valid", 64'(nval - nv0), 64'd0);
        run_scn(tbl[0].offs, 4'hF, -1, 0, 0, 1'b1);
        chk("post_reset_seq", 64'(o_seq), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
